// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer and its datapath.
package matmul_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 17;

  localparam logic [2:0] LAST_A_IDX = 3'd3;
  localparam logic [2:0] LAST_B_IDX = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    DRAIN
  } state_t;

endpackage

// File: rtl/matrix_multiply.sv
// 2x2 8-bit matrix-multiply datapath: eight operand registers written while execute=0,
// combinational multiply-add of the element picked by sel_out.
module matrix_multiply
  import matmul_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         sel_in,
  input  logic [OPND_W-1:0]  input_val,
  input  logic               execute,
  input  logic [1:0]         sel_out,
  output logic [RES_W-1:0]   result
);

  logic [OPND_W-1:0] opnd [8];
  logic [15:0]       prod0;
  logic [15:0]       prod1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) opnd[i] <= '0;
    end else if (!execute) begin
      opnd[sel_in] <= input_val;
    end
  end

  // Operand index is {is_b, row, col}: A[r][k] -> {0,r,k}, B[k][c] -> {1,k,c}.
  always_comb begin
    prod0  = {8'd0, opnd[{1'b0, sel_out[1], 1'b0}]} * {8'd0, opnd[{1'b1, 1'b0, sel_out[0]}]};
    prod1  = {8'd0, opnd[{1'b0, sel_out[1], 1'b1}]} * {8'd0, opnd[{1'b1, 1'b1, sel_out[0]}]};
    result = {1'b0, prod0} + {1'b0, prod1};
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences the 2x2 matmul datapath through one job: load 4 or 8 operand beats,
// hold execute for SETTLE_CYCLES, then drain the four products as a valid/ready stream.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              reuse_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [1:0]        res_idx,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic [2:0]        mm_sel_in,
  output logic [OPND_W-1:0] mm_input_val,
  output logic              mm_execute,
  output logic [1:0]        mm_sel_out,
  input  logic [RES_W-1:0]  mm_result
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] load_idx, load_idx_nxt;
  logic [2:0] last_idx, last_idx_nxt;
  logic [1:0] out_idx, out_idx_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic       done_nxt;
  logic       in_hs;
  logic       res_hs;

  // Gating with reset keeps the datapath write-protected even if reset lands mid-load.
  assign in_ready     = (state == LOAD) && !reset;
  assign in_hs        = in_valid && in_ready;
  assign mm_execute   = !in_hs;
  assign mm_sel_in    = load_idx;
  assign mm_input_val = in_data;

  assign res_valid  = (state == DRAIN);
  assign res_hs     = res_valid && res_ready;
  assign mm_sel_out = out_idx;
  assign res_idx    = out_idx;
  assign res_data   = mm_result;
  assign res_last   = res_valid && (out_idx == 2'd3);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_idx   <= '0;
      last_idx   <= LAST_B_IDX;
      out_idx    <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_idx   <= load_idx_nxt;
      last_idx   <= last_idx_nxt;
      out_idx    <= out_idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_idx_nxt   = load_idx;
    last_idx_nxt   = last_idx;
    out_idx_nxt    = out_idx;
    settle_cnt_nxt = settle_cnt;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = LOAD;
          load_idx_nxt = '0;
          last_idx_nxt = reuse_b ? LAST_A_IDX : LAST_B_IDX;
        end
      end
      LOAD: begin
        if (in_hs) begin
          if (load_idx == last_idx) begin
            load_idx_nxt   = '0;
            settle_cnt_nxt = '0;
            out_idx_nxt    = '0;
            state_nxt      = (SETTLE_CYCLES == 0) ? DRAIN : SETTLE;
          end else begin
            load_idx_nxt = load_idx + 3'd1;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt   = DRAIN;
          out_idx_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (res_hs) begin
          if (out_idx == 2'd3) begin
            state_nxt   = IDLE;
            out_idx_nxt = '0;
            done_nxt    = 1'b1;
          end else begin
            out_idx_nxt = out_idx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences the 2x2 8-bit matrix-multiply datapath through one job: load operands, let the product settle, drain results.
- Takes operands as a valid/ready stream and returns the four 17-bit products as a valid/ready stream.
- Drives the datapath's sel_in/input_val/execute/sel_out pins directly and sits between the host interface and the datapath.
- Supports B-reuse jobs that reload only A.

Parameters:
- SETTLE_CYCLES, 2, cycles execute is held high after the last operand write before the first result is presented (multicycle budget for the combinational multiply-add); 0..15 legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin job; sampled only in IDLE
- reuse_b  in  1  sampled with start; 1 = load only A (4 beats), keep previous B
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_data  in  8  operand value
- res_valid  out  1  result beat valid
- res_ready  in  1  result consumer ready
- res_data  out  17  result value
- res_idx  out  2  result element {row,col}
- res_last  out  1  high with the C[1][1] beat
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- mm_sel_in  out  3  datapath operand select
- mm_input_val  out  8  datapath operand value
- mm_execute  out  1  datapath execute (0 = write enabled)
- mm_sel_out  out  2  datapath result select
- mm_result  in  17  datapath result

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values: state=IDLE, load_idx=0, out_idx=0, settle count=0, mm_execute=1, in_ready=0, res_valid=0, done=0, busy=0, mm_sel_in=0, mm_sel_out=0.
- Write-enable rule: the datapath writes input_val into the register selected by sel_in on every clock where execute=0.
  - mm_execute = ~(in_valid & in_ready), combinational.
  - mm_execute is 1 in every other cycle, including IDLE, SETTLE, DRAIN and reset.
  - No datapath register is ever written without an accepted beat.
- mm_sel_in = load_idx; mm_input_val = in_data (passthrough).
- Beat order: index 0..7 = A00, A01, A10, A11, B00, B01, B10, B11.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD; load_idx=0; last_idx latched as 3 if reuse_b, else 7.
- LOAD:
  - in_ready=1.
  - On handshake: load_idx++.
  - Handshake at load_idx==last_idx -> SETTLE with count=0, or straight to DRAIN if SETTLE_CYCLES==0.
  - in_valid low stalls indefinitely with no write.
- SETTLE: count++ each cycle; at count==SETTLE_CYCLES-1 -> DRAIN, out_idx=0.
- DRAIN:
  - res_valid=1; mm_sel_out=out_idx; res_idx=out_idx.
  - res_data=mm_result, combinational, same cycle.
  - res_last=(out_idx==3).
  - On handshake: out_idx++. Handshake at out_idx==3 -> IDLE and done=1 for the next cycle.
  - res_ready low holds all outputs stable.
- start is ignored while busy. The first start after reset with reuse_b=1 uses whatever B the datapath holds; this is legal, not an error.
- Reset asserted mid-job: next cycle is IDLE with reset values. Partially loaded datapath registers are not cleared by this block.
- start in the same cycle that done pulses (state is already IDLE): accepted and enters LOAD.
- Counters are sized exactly (load 3 bits, out 2 bits, settle 4 bits); no wrap beyond the terminal values.

Decomposition:
- Shared package matmul_pkg:
  - state enum (IDLE, LOAD, SETTLE, DRAIN)
  - OPND_W=8, RES_W=17
  - LAST_A_IDX=3, LAST_B_IDX=7
- No sub-module; a single FSM with its counters.
- The bench instantiates matrix_multiply behind this block, with its reset_n tied to ~reset.

Test Plan:
- Full job, no stalls: A=[1 2;3 4], B=[5 6;7 8], res_ready=1 -> results 19, 22, 43, 50 with idx 0..3; res_last on 50; done one cycle later; first res_valid exactly SETTLE_CYCLES+1 cycles after the last operand handshake.
- Reuse B: after the previous job, start with reuse_b=1 and A=[2 0;0 2] -> exactly 4 beats accepted, results 10, 12, 14, 16.
- Max values with random in_valid/res_ready stalls: all operands 255 -> every result 130050 (17'h1FC02); no datapath write on cycles with in_valid=0; outputs stable while res_ready=0.
- Spurious start: pulse start during LOAD and during DRAIN -> no state change, and the job completes normally.
- Reset mid-LOAD after 3 beats -> IDLE, busy=0, mm_execute=1. A new full job with the first test's values then yields 19, 22, 43, 50.
- SETTLE_CYCLES=0 build: DRAIN is entered the cycle after the last operand beat and C00 is valid immediately; start in the done cycle starts the next job.
